// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential integer square root of a 16-bit radicand, one root bit per clock.
// Optional remainder output port enabled by defining SQRT_REM_EN.
`default_nettype none

// 16-bit two-level carry-lookahead adder (4-bit groups).
module sqrt_cla16 (
   input  logic [15:0] A_i,
   input  logic [15:0] B_i,
   input  logic        Ci_i,
   output logic [15:0] S_o,
   output logic        Co_o
);
   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [4:0]  gc;

   assign g = A_i & B_i;
   assign p = A_i ^ B_i;

   generate
      for (genvar k = 0; k < 4; k++) begin : g_grp
         localparam int B = 4 * k;
         assign c[B]   = gc[k];
         assign c[B+1] = g[B] | (p[B] & gc[k]);
         assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
         assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                       | (p[B+2] & p[B+1] & p[B] & gc[k]);
         assign gg[k]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B]);
         assign gp[k]  = &p[B+3:B];
      end
   endgenerate

   // Second-level lookahead across the four groups.
   assign gc[0] = Ci_i;
   assign gc[1] = gg[0] | (gp[0] & gc[0]);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & gc[0]);
   assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);

   assign S_o  = p ^ c;
   assign Co_o = gc[4];
endmodule

module sqrt_seq (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [15:0] rad_i,
   output logic        ready_o,
   output logic        done_o,
`ifdef SQRT_REM_EN
   output logic [8:0]  rem_o,
`endif
   output logic [7:0]  root_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] rad_q;
   logic [7:0]  root_q;
   logic [8:0]  rem_q;
   logic [2:0]  cnt;
   logic [7:0]  root_out;
   logic [8:0]  rem_out;

   logic [1:0]  pair;
   logic [9:0]  trial;
   logic [9:0]  dval;
   logic [15:0] sum;
   logic        no_borrow;
   logic [7:0]  root_nxt;
   logic [8:0]  rem_nxt;
   logic        accept;

   // The partial remainder never exceeds 8 bits before the shift-in, so trial is 10 bits.
   assign pair  = {rad_q[{cnt, 1'b1}], rad_q[{cnt, 1'b0}]};
   assign trial = {rem_q[7:0], pair};
   assign dval  = {root_q, 2'b01};

   sqrt_cla16 u_sub (
      .A_i  ({6'b0, trial}),
      .B_i  (~{6'b0, dval}),
      .Ci_i (1'b1),
      .S_o  (sum),
      .Co_o (no_borrow)
   );

   logic unused_bits;
   assign unused_bits = &{1'b0, sum[15:10], rem_q[8]};

   assign root_nxt = {root_q[6:0], no_borrow};
   assign rem_nxt  = no_borrow ? sum[8:0] : trial[8:0];
   assign accept   = (state == IDLE) && start_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = CALC;
         CALC:    if (cnt == 3'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rad_q    <= '0;
         root_q   <= '0;
         rem_q    <= '0;
         cnt      <= '0;
         root_out <= '0;
         rem_out  <= '0;
      end else if (accept) begin
         rad_q  <= rad_i;
         root_q <= '0;
         rem_q  <= '0;
         cnt    <= 3'd7;
      end else if (state == CALC) begin
         root_q <= root_nxt;
         rem_q  <= rem_nxt;
         cnt    <= cnt - 3'd1;
         if (cnt == 3'd0) begin
            root_out <= root_nxt;
            rem_out  <= rem_nxt;
         end
      end
   end

   assign ready_o = (state == IDLE);
   assign done_o  = (state == DONE);
   assign root_o  = root_out;
`ifdef SQRT_REM_EN
   assign rem_o   = rem_out;
`else
   logic unused_rem;
   assign unused_rem = &{1'b0, rem_out};
`endif
endmodule

`default_nettype wire

// File: tb/tb_sqrt_seq.sv
// Self-checking bench for sqrt_seq: directed corner cases plus random radicands vs. an arithmetic model.
`timescale 1ns/1ps
module tb_sqrt_seq;
   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [15:0] rad_i = '0;
   logic        ready_o;
   logic        done_o;
   logic [7:0]  root_o;
   logic [8:0]  rem_o;
   int          tests = 0;
   int          fails = 0;

`ifndef SQRT_REM_EN
   assign rem_o = '0;
`endif

   sqrt_seq dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .start_i (start_i),
      .rad_i   (rad_i),
      .ready_o (ready_o),
      .done_o  (done_o),
`ifdef SQRT_REM_EN
      .rem_o   (rem_o),
`endif
      .root_o  (root_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_root(input int rad);
      int r = 0;
      while ((r + 1) * (r + 1) <= rad) r++;
      return r;
   endfunction

   task automatic check_result(input string tag, input logic [15:0] r);
      int er = model_root(int'(r));
      check({tag, "_root"}, 32'(root_o), 32'(er));
`ifdef SQRT_REM_EN
      check({tag, "_rem"}, 32'(rem_o), 32'(int'(r) - er * er));
`endif
   endtask

   // One full transaction; rad_i is scrambled after acceptance to show it is not re-sampled.
   task automatic run_one(input string tag, input logic [15:0] r);
      int waited = 0;
      while (!ready_o && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_ready_before"}, 32'(ready_o), 32'd1);
      rad_i   = r;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      rad_i   = 16'($urandom);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 9) begin
            check({tag, "_done_t8"}, 32'(done_o), 32'd1);
            check({tag, "_ready_in_done"}, 32'(ready_o), 32'd0);
         end else if (done_o !== 1'b0 || ready_o !== 1'b0) begin
            check({tag, "_calc_flags"}, {30'd0, done_o, ready_o}, 32'd0);
         end
      end
      check_result(tag, r);
      @(negedge clk);
      check({tag, "_done_drop"}, 32'(done_o), 32'd0);
      check({tag, "_ready_back"}, 32'(ready_o), 32'd1);
      check_result({tag, "_held"}, r);
   endtask

   initial begin
      int ndone;
      int nready;
      int first_done;
      int last_done;
      logic [15:0] rr;

      repeat (3) @(negedge clk);
      check("reset_ready", 32'(ready_o), 32'd1);
      check("reset_done", 32'(done_o), 32'd0);
      check("reset_root", 32'(root_o), 32'd0);
      check("reset_rem", 32'(rem_o), 32'd0);

      // Start coincident with reset is dropped.
      start_i = 1'b1;
      rad_i   = 16'h1234;
      @(negedge clk);
      rst_i   = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      check("rst_start_dropped", 32'(ready_o), 32'd1);

      run_one("zero", 16'h0000);
      run_one("ffff", 16'hFFFF);
      run_one("x0090", 16'h0090);
      run_one("x00c8", 16'h00C8);

      // Start held high: one result every 10 cycles.
      rad_i      = 16'h00C8;
      start_i    = 1'b1;
      ndone      = 0;
      nready     = 0;
      first_done = -1;
      last_done  = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done_o) begin
            if (first_done < 0) first_done = k;
            last_done = k;
            ndone++;
         end
         if (ready_o) nready++;
      end
      start_i = 1'b0;
      check("held_done_count", 32'(ndone), 32'd4);
      check("held_ready_count", 32'(nready), 32'd4);
      check("held_first_done", 32'(first_done), 32'd9);
      check("held_last_done", 32'(last_done), 32'd39);
      check_result("held", 16'h00C8);
      repeat (12) @(negedge clk);

      // Reset in the middle of CALC.
      rad_i   = 16'hFFFF;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("midrst_ready", 32'(ready_o), 32'd1);
      check("midrst_done", 32'(done_o), 32'd0);
      check("midrst_root", 32'(root_o), 32'd0);
      check("midrst_rem", 32'(rem_o), 32'd0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done_o) ndone++;
      end
      check("midrst_no_done", 32'(ndone), 32'd0);

      // rad_i change and extra start during CALC are ignored.
      rad_i   = 16'h0064;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      ndone   = 0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (k == 2) rad_i = 16'hFFFF;
         if (k == 3) start_i = 1'b1;
         if (k == 4) start_i = 1'b0;
         if (done_o) ndone++;
      end
      check("ignore_done_count", 32'(ndone), 32'd1);
      check("ignore_root", 32'(root_o), 32'h0A);
      check("ignore_rem", 32'(rem_o), 32'd0);

      run_one("x0001", 16'h0001);
      run_one("x0003", 16'h0003);
      run_one("xfe01", 16'hFE01);
      run_one("xfe00", 16'hFE00);
      for (int i = 0; i < 400; i++) begin
         rr = 16'($urandom);
         run_one("rand", rr);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      fails++;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/sqrt_seq.md
SQRT_SEQ -- requirements
Module: sqrt_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  request to start; sampled only while ready_o=1.
REQ-005 rad_i  input  16  unsigned radicand; captured on the accepting edge.
REQ-006 ready_o  output  1  high only in IDLE, meaning the block can accept start_i.
REQ-007 done_o  output  1  one-cycle pulse marking a valid result.
REQ-008 root_o  output  8  floor(sqrt(rad)); held stable until the next accepted start.
REQ-009 rem_o  output  9  rad - root^2; exists only when SQRT_REM_EN is defined.

Function
REQ-010 The block SHALL compute the integer square root with the restoring digit-by-digit algorithm, one root bit per clock, MSB first.
REQ-011 FSM states: IDLE, CALC, DONE.
- IDLE->CALC on start_i=1.
- CALC->DONE after the 8th iteration.
- DONE->IDLE unconditionally after one cycle.
REQ-012 Accepting edge t0: the block SHALL latch rad_i, clear the root and remainder registers, load the iteration counter with 7, and enter CALC.
REQ-013 Iteration k (k=7..0), one per edge t1..t8:
- trial = {rem, rad[2k+1:2k]} (10 bits).
- D = {root, 2'b01} (10 bits).
- diff = trial - D.
- If no borrow: rem = diff and the root LSB shifts in 1.
- Otherwise: rem = trial[8:0] and the root LSB shifts in 0.
REQ-014 The subtraction SHALL be done by one instance of the team's 16-bit CLA adder, not by a behavioural '-':
- A_i = trial zero-extended to 16 bits.
- B_i = ~(D zero-extended to 16 bits).
- Ci_i = 1.
- Co_o = 1 means no borrow.
- S_o[9:0] is the difference.
REQ-015 Latency: done_o SHALL be high in exactly the cycle after edge t8, i.e. 8 clocks after the accepting edge; ready_o returns high one cycle later.
REQ-016 The next start SHALL be accepted no earlier than edge t9 (throughput: one result per 10 cycles).
REQ-017 start_i asserted in CALC or DONE SHALL be ignored, with no effect on the computation or on rad latching.
REQ-018 Changes on rad_i after the accepting edge SHALL NOT affect the result.
REQ-019 root_o and rem_o SHALL update only at edge t8 (from internal registers) and hold their values through IDLE until the next t8.
REQ-020 The remainder SHALL always satisfy 0 <= rem <= 2*root and fit in 9 bits; no overflow path exists.

Reset
REQ-021 When rst_i=1 at a rising edge, the block SHALL go to IDLE and clear all state, regardless of the current state (including mid-CALC).
REQ-022 Output values after reset: ready_o=1, done_o=0, root_o=0, rem_o=0.
REQ-023 A reset in the same cycle as start_i=1 SHALL take priority; the start is dropped.
REQ-024 The first start SHALL be accepted no earlier than the first edge with rst_i=0.

Configuration
REQ-025 Macro SQRT_REM_EN:
- Defined: the rem_o port exists and carries the final remainder per REQ-019.
- Undefined: the rem_o port is omitted; root_o timing and value are unchanged, and the internal remainder register still exists.

Verification
REQ-026 Reset, then rad_i=16'h0000 with start -> done_o 8 cycles later, root_o=8'h00, rem_o=9'h000.
REQ-027 rad_i=16'hFFFF -> root_o=8'hFF, rem_o=9'h1FE; rad_i=16'h0090 -> root_o=8'h0C, rem_o=0.
REQ-028 rad_i=16'h00C8 -> root_o=8'h0E, rem_o=9'h004; then start_i held high continuously -> exactly one done_o pulse per 10 cycles, with ready_o low throughout CALC.
REQ-029 Start with 16'hFFFF, assert rst_i at the 4th CALC cycle -> next cycle ready_o=1, done_o=0, root_o=0, and no done_o pulse follows.
REQ-030 Start with 16'h0064, change rad_i to 16'hFFFF at t2 and pulse start_i at t3 -> root_o=8'h0A, rem_o=0, one done_o pulse only.
REQ-031 Exhaustive sweep of rad 0..65535 against a reference model -> root^2 <= rad < (root+1)^2 and rem = rad - root^2, run both with and without SQRT_REM_EN.
